// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive frame controller and its environment:
// serial line and frame configuration, link to edge_bit_counter, received word and status.
interface uart_rx_fsm_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [3:0]            edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  enable;
   logic                  reset_bit_cnt;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   // Receiver-side view: the frame controller itself.
   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
      output enable, reset_bit_cnt, P_DATA, data_valid, par_err, stp_err, busy
   );

   // Environment view: line driver, counter and consumer of the received word.
   modport master (
      output RX_IN, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
      input  enable, reset_bit_cnt, P_DATA, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Works with an external edge/bit counter running
// at 8 clocks per bit: majority-samples the line mid-bit, checks start, parity and
// stop bits, deserialises LSB first and publishes good words with a 1-cycle pulse.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int EDGE_MAX   = 7
) (
   input  logic          CLK,
   input  logic          RST,
   uart_rx_fsm_if.slave  bus
);

   localparam logic [3:0] EDGE_LAST = 4'(EDGE_MAX);
   localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Two-of-three vote used to reject single-sample line noise.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity bit a correct transmitter sends for word w (odd=1 selects odd parity).
   function automatic logic parity_expected(input logic [DATA_WIDTH-1:0] w, input logic odd);
      return odd ? ~^w : ^w;
   endfunction

   state_t                state_q, state_d;
   logic                  s3_q, s3_d;
   logic                  s4_q, s4_d;
   logic                  sampled_q, sampled_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
   logic                  bit_end_s;

   assign bit_end_s = (bus.edge_cnt == EDGE_LAST);

   // State and datapath registers; async reset returns everything to idle defaults.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         s3_q         <= 1'b0;
         s4_q         <= 1'b0;
         sampled_q    <= 1'b0;
         shift_q      <= {DATA_WIDTH{1'b0}};
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         p_data_q     <= {DATA_WIDTH{1'b0}};
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         s3_q         <= s3_d;
         s4_q         <= s4_d;
         sampled_q    <= sampled_d;
         shift_q      <= shift_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   // Mid-bit sampling plus next-state and datapath decisions taken at each bit end.
   always_comb begin
      state_d      = state_q;
      s3_d         = s3_q;
      s4_d         = s4_q;
      sampled_d    = sampled_q;
      shift_d      = shift_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = par_err_q;
      stp_err_d    = stp_err_q;

      // Samples are taken around the bit centre; the vote completes at edge 5.
      if (bus.edge_cnt == 4'd3) begin
         s3_d = bus.RX_IN;
      end else if (bus.edge_cnt == 4'd4) begin
         s4_d = bus.RX_IN;
      end else if (bus.edge_cnt == 4'd5) begin
         sampled_d = majority3(s3_q, s4_q, bus.RX_IN);
      end else begin
         sampled_d = sampled_q;
      end

      case (state_q)
         IDLE: begin
            if (bus.RX_IN == 1'b0) begin
               // Configuration is frozen for the whole frame; old flags drop here.
               state_d   = START;
               par_en_d  = bus.PAR_EN;
               par_typ_d = bus.PAR_TYP;
               par_err_d = 1'b0;
               stp_err_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               // A start bit that reads high mid-bit was a glitch: drop silently.
               state_d = sampled_q ? IDLE : DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_d = {sampled_q, shift_q[DATA_WIDTH-1:1]};
               if (bus.bit_cnt == LAST_BIT) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               par_err_d = (sampled_q != parity_expected(shift_q, par_typ_q));
               state_d   = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               stp_err_d = ~sampled_q;
               if (sampled_q && !par_err_q) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end else begin
                  p_data_d = p_data_q;
               end
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counter control and busy are pure decodes of the current state.
   assign bus.enable        = (state_q != IDLE);
   assign bus.reset_bit_cnt = (state_q == IDLE);
   assign bus.busy          = (state_q != IDLE);
   assign bus.P_DATA        = p_data_q;
   assign bus.data_valid    = data_valid_q;
   assign bus.par_err       = par_err_q;
   assign bus.stp_err       = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter, drives serial frames at
// 8 clocks per bit and compares against a frame-level reference model.
module tb_uart_rx_fsm;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   vcount = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_pdata = 8'h00;

   uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();

   uart_rx_fsm #(.DATA_WIDTH(8), .EDGE_MAX(7)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Behavioural edge/bit counter: edge_cnt 0..7 per bit, bit_cnt counts finished bits.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.edge_cnt <= 4'd0;
         bus.bit_cnt  <= 4'd0;
      end else if (bus.reset_bit_cnt || !bus.enable) begin
         bus.edge_cnt <= 4'd0;
         bus.bit_cnt  <= 4'd0;
      end else if (bus.edge_cnt == 4'd7) begin
         bus.edge_cnt <= 4'd0;
         bus.bit_cnt  <= bus.bit_cnt + 4'd1;
      end else begin
         bus.edge_cnt <= bus.edge_cnt + 4'd1;
      end
   end

   // Record every data_valid cycle and the word published with it.
   always @(negedge CLK) begin
      if (bus.data_valid === 1'b1) begin
         vcount = vcount + 1;
         got_q.push_back(bus.P_DATA);
      end
   end

   // Reference: {valid, par_err, stp_err} from the frame contents alone.
   function automatic logic [2:0] frame_model(input logic [7:0] d, input logic pe,
                                              input logic pt, input logic pb, input logic sb);
      logic good_pb;
      logic perr;
      good_pb = logic'($countones(d) % 2) ^ pt;
      perr    = pe && (pb != good_pb);
      return {(!perr && sb), perr, !sb};
   endfunction

   task automatic drive_bit(input logic b);
      bus.RX_IN = b;
      repeat (8) @(posedge CLK);
      #1;
   endtask

   // One full frame on the line; configuration is scrambled after the start bit.
   task automatic drive_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pb, input logic sb);
      bus.PAR_EN  = pe;
      bus.PAR_TYP = pt;
      drive_bit(1'b0);
      bus.PAR_EN  = 1'($urandom);
      bus.PAR_TYP = 1'($urandom);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pe) drive_bit(pb);
      drive_bit(sb);
      bus.RX_IN = 1'b1;
   endtask

   task automatic wait_idle(output logic tmo);
      int n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         @(posedge CLK);
         #1;
         n++;
      end
      tmo = (bus.busy !== 1'b0);
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({bus.busy, bus.enable, bus.reset_bit_cnt, bus.data_valid, bus.par_err, bus.stp_err} !== 6'b001000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 001000", {bus.busy, bus.enable, bus.reset_bit_cnt, bus.data_valid, bus.par_err, bus.stp_err});
      end
      checks++;
      if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA); end
      RST = 1'b0;
      exp_pdata = 8'h00;
      @(posedge CLK); #1;
   endtask

   task automatic test_spec_frames();
      logic tmo;
      int   v0;
      logic [7:0] d [4]  = '{8'hA5, 8'h3C, 8'h3C, 8'h81};
      logic       pe [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic       pt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic       sb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] m;
      for (int k = 0; k < 4; k++) begin
         v0 = vcount;
         m  = frame_model(d[k], pe[k], pt[k], 1'b0, sb[k]);
         if (m[2]) exp_pdata = d[k];
         drive_frame(d[k], pe[k], pt[k], 1'b0, sb[k]);
         wait_idle(tmo);
         checks++;
         if (tmo !== 1'b0) begin errors++; $display("FAIL spec%0d_timeout: busy stuck, expected idle", k); end
         checks++;
         if (vcount - v0 !== int'(m[2])) begin errors++; $display("FAIL spec%0d_valid: got %0d pulses expected %0d", k, vcount - v0, m[2]); end
         checks++;
         if ({bus.par_err, bus.stp_err} !== m[1:0]) begin errors++; $display("FAIL spec%0d_flags: got %b expected %b", k, {bus.par_err, bus.stp_err}, m[1:0]); end
         checks++;
         if (bus.P_DATA !== exp_pdata) begin errors++; $display("FAIL spec%0d_pdata: got %h expected %h", k, bus.P_DATA, exp_pdata); end
      end
      // Good 0x55 after the stop error: flag must drop as soon as the frame starts.
      v0 = vcount;
      fork
         drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (3) @(negedge CLK);
            checks++;
            if (bus.stp_err !== 1'b0) begin errors++; $display("FAIL stp_clear_at_start: got %b expected 0", bus.stp_err); end
         end
      join
      wait_idle(tmo);
      exp_pdata = 8'h55;
      checks++;
      if (vcount - v0 !== 1 || bus.P_DATA !== 8'h55 || tmo !== 1'b0) begin
         errors++; $display("FAIL after_stp_err: got %0d pulses data %h expected 1 pulse data 55", vcount - v0, bus.P_DATA);
      end
   endtask

   task automatic test_glitch();
      int n = 0;
      int v0 = vcount;
      bus.RX_IN = 1'b0;
      do begin
         @(posedge CLK); #1;
         n++;
         if (n == 2) bus.RX_IN = 1'b1;
      end while (bus.busy === 1'b1 && n < 40);
      repeat (3) @(posedge CLK); #1;
      checks++;
      if (n !== 9) begin errors++; $display("FAIL glitch_duration: got %0d cycles expected 9", n); end
      checks++;
      if ({bus.enable, bus.par_err, bus.stp_err} !== 3'b000 || vcount !== v0) begin
         errors++; $display("FAIL glitch_quiet: got en/pe/se %b pulses %0d expected 000 and 0", {bus.enable, bus.par_err, bus.stp_err}, vcount - v0);
      end
   endtask

   task automatic test_back_to_back();
      logic tmo;
      int   v0 = vcount;
      got_q.delete();
      drive_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
      drive_frame(8'h1E, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle(tmo);
      exp_pdata = 8'h1E;
      checks++;
      if (tmo !== 1'b0 || vcount - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 2", vcount - v0); end
      checks++;
      if (got_q.size() != 2 || got_q[0] !== 8'hC3 || got_q[1] !== 8'h1E) begin
         errors++; $display("FAIL b2b_words: got %0d words expected C3 then 1E", got_q.size());
      end
   endtask

   task automatic test_random();
      logic tmo;
      int   v0;
      logic [7:0] d;
      logic pe, pt, pb, sb;
      logic [2:0] m;
      for (int k = 0; k < 24; k++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         pb = 1'($urandom);
         sb = ($urandom_range(0, 4) != 0);
         m  = frame_model(d, pe, pt, pb, sb);
         if (m[2]) exp_pdata = d;
         v0 = vcount;
         drive_frame(d, pe, pt, pb, sb);
         wait_idle(tmo);
         checks++;
         if (tmo !== 1'b0 || vcount - v0 !== int'(m[2]) || {bus.par_err, bus.stp_err} !== m[1:0] || bus.P_DATA !== exp_pdata) begin
            errors++;
            $display("FAIL random%0d: d=%h pe=%b pt=%b pb=%b sb=%b got pulses %0d flags %b data %h expected %0d %b %h",
                     k, d, pe, pt, pb, sb, vcount - v0, {bus.par_err, bus.stp_err}, bus.P_DATA, m[2], m[1:0], exp_pdata);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic tmo;
      int   v0;
      logic [7:0] w = 8'hF0;
      bus.PAR_EN = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(w[i]);
      bus.RX_IN = w[4];
      repeat (3) @(posedge CLK); #1;
      v0 = vcount;
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if ({bus.busy, bus.enable, bus.reset_bit_cnt, bus.data_valid, bus.par_err, bus.stp_err} !== 6'b001000 || bus.P_DATA !== 8'h00) begin
         errors++; $display("FAIL mid_reset: got ctrl %b data %h expected 001000 00",
                             {bus.busy, bus.enable, bus.reset_bit_cnt, bus.data_valid, bus.par_err, bus.stp_err}, bus.P_DATA);
      end
      @(posedge CLK); #1;
      bus.RX_IN = 1'b1;
      RST = 1'b0;
      exp_pdata = 8'h00;
      repeat (3) @(posedge CLK); #1;
      drive_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle(tmo);
      checks++;
      if (tmo !== 1'b0 || vcount - v0 !== 1 || bus.P_DATA !== 8'h0F) begin
         errors++; $display("FAIL post_reset_frame: got %0d pulses data %h expected 1 pulse data 0F", vcount - v0, bus.P_DATA);
      end
   endtask

   initial begin
      test_reset();
      test_spec_frames();
      test_glitch();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
